// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - opcodes, state encodings, ALU and mux select codes for the multicycle MIPS controller
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    EXEC_R   = 4'd6,
    EXEC_I   = 4'd7,
    ALU_WB   = 4'd8,
    BRANCH   = 4'd9,
    JUMP     = 4'd10,
    JAL_ST   = 4'd11,
    TRAP     = 4'd12
  } stateT;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0c;
  localparam logic [5:0] OP_ORI  = 6'h0d;
  localparam logic [5:0] OP_LUI  = 6'h0f;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2b;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_LUI   = 3'b011;
  localparam logic [2:0] ALU_ADDI  = 3'b100;
  localparam logic [2:0] ALU_ORI   = 3'b101;
  localparam logic [2:0] ALU_ANDI  = 3'b110;
  localparam logic [2:0] ALU_FUNCT = 3'b111;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] REG_DST_RT = 2'b00;
  localparam logic [1:0] REG_DST_RD = 2'b01;
  localparam logic [1:0] REG_DST_RA = 2'b10;

  localparam logic [1:0] MEMTOREG_ALUOUT = 2'b00;
  localparam logic [1:0] MEMTOREG_MDR    = 2'b01;
  localparam logic [1:0] MEMTOREG_PC     = 2'b10;

  function automatic logic [2:0] iTypeAluOp(input logic [5:0] op);
    case (op)
      OP_ORI:  return ALU_ORI;
      OP_ANDI: return ALU_ANDI;
      OP_LUI:  return ALU_LUI;
      default: return ALU_ADDI;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// rtl/multicycle_ctrl_decode.sv - combinational State/OP to datapath control strobes and selects
module multicycle_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  logic [3:0] state,
  input  logic [5:0] OP,
  input  logic       MemReady,
  input  logic       rtype,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       PCWriteCondEQ,
  output logic       PCWriteCondNE,
  output logic [1:0] PCSource,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic       RegWrite
);

  always_comb begin
    IorD          = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    PCWrite       = 1'b0;
    PCWriteCondEQ = 1'b0;
    PCWriteCondNE = 1'b0;
    PCSource      = PC_SRC_ALU;
    ALUSrcA       = 1'b0;
    ALUSrcB       = SRCB_RT;
    ALUOp         = ALU_ADD;
    RegDst        = REG_DST_RT;
    MemtoReg      = MEMTOREG_ALUOUT;
    RegWrite      = 1'b0;
    case (state)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWrite = MemReady;
        PCWrite = MemReady;
      end
      DECODE: ALUSrcB = SRCB_IMM_SH2;
      MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      MEM_WB: begin
        MemtoReg = MEMTOREG_MDR;
        RegWrite = 1'b1;
      end
      MEM_WR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALU_FUNCT;
      end
      EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = iTypeAluOp(OP);
      end
      // destination register was decided one state earlier and held in rtype
      ALU_WB: begin
        RegWrite = 1'b1;
        RegDst   = rtype ? REG_DST_RD : REG_DST_RT;
      end
      BRANCH: begin
        ALUSrcA       = 1'b1;
        ALUOp         = ALU_SUB;
        PCSource      = PC_SRC_ALUOUT;
        PCWriteCondEQ = (OP == OP_BEQ);
        PCWriteCondNE = (OP == OP_BNE);
      end
      JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PC_SRC_JUMP;
      end
      JAL_ST: begin
        PCWrite  = 1'b1;
        PCSource = PC_SRC_JUMP;
        RegDst   = REG_DST_RA;
        MemtoReg = MEMTOREG_PC;
        RegWrite = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle MIPS control FSM with memory wait timeout and illegal-opcode trap
// Optional retired-instruction counter output enabled by MULTICYCLE_CTRL_RETIRE_CNT_EN.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_WIDTH    = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OP,
  input  logic       MemReady,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       PCWriteCondEQ,
  output logic       PCWriteCondNE,
  output logic [1:0] PCSource,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic       RegWrite,
  output logic       Illegal,
`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
  output logic [CNT_WIDTH-1:0] InstrRetired,
`endif
  output logic [3:0] State
);

  localparam int WAIT_W = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX + 1) : 1;

  stateT             stateQ, stateNext;
  logic [WAIT_W-1:0] waitCnt;
  logic              illegalQ, rtypeQ;
  logic              waitState, waitHit;
  logic              memReadDec, memWriteDec, irWriteDec, pcWriteDec;
  logic              condEqDec, condNeDec, regWriteDec;

  assign waitState = (stateQ == FETCH) || (stateQ == MEM_RD) || (stateQ == MEM_WR);
  // trap on the edge where the count would reach the limit; a ready in that cycle wins
  assign waitHit   = (MEM_WAIT_MAX != 0) && waitState && !MemReady &&
                     (waitCnt == WAIT_W'(MEM_WAIT_MAX - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      stateQ   <= FETCH;
      waitCnt  <= '0;
      illegalQ <= 1'b0;
      rtypeQ   <= 1'b0;
    end else begin
      stateQ  <= stateNext;
      waitCnt <= (waitState && !MemReady && stateNext == stateQ) ? waitCnt + 1'b1 : '0;
      if (stateNext == TRAP) illegalQ <= 1'b1;
      if (stateQ == EXEC_R)      rtypeQ <= 1'b1;
      else if (stateQ == EXEC_I) rtypeQ <= 1'b0;
    end
  end

  always_comb begin
    stateNext = FETCH;
    case (stateQ)
      FETCH:    stateNext = MemReady ? DECODE : (waitHit ? TRAP : FETCH);
      DECODE: begin
        case (OP)
          OP_LW, OP_SW:                      stateNext = MEM_ADDR;
          OP_R:                              stateNext = EXEC_R;
          OP_ADDI, OP_ORI, OP_ANDI, OP_LUI:  stateNext = EXEC_I;
          OP_BEQ, OP_BNE:                    stateNext = BRANCH;
          OP_J:                              stateNext = JUMP;
          OP_JAL:                            stateNext = JAL_ST;
          default:                           stateNext = TRAP;
        endcase
      end
      MEM_ADDR: stateNext = (OP == OP_SW) ? MEM_WR : MEM_RD;
      MEM_RD:   stateNext = MemReady ? MEM_WB : (waitHit ? TRAP : MEM_RD);
      MEM_WR:   stateNext = MemReady ? FETCH : (waitHit ? TRAP : MEM_WR);
      EXEC_R:   stateNext = ALU_WB;
      EXEC_I:   stateNext = ALU_WB;
      TRAP:     stateNext = TRAP;
      default:  stateNext = FETCH;
    endcase
  end

  multicycle_ctrl_decode uDecode (
    .state         (stateQ),
    .OP            (OP),
    .MemReady      (MemReady),
    .rtype         (rtypeQ),
    .IorD          (IorD),
    .MemRead       (memReadDec),
    .MemWrite      (memWriteDec),
    .IRWrite       (irWriteDec),
    .PCWrite       (pcWriteDec),
    .PCWriteCondEQ (condEqDec),
    .PCWriteCondNE (condNeDec),
    .PCSource      (PCSource),
    .ALUSrcA       (ALUSrcA),
    .ALUSrcB       (ALUSrcB),
    .ALUOp         (ALUOp),
    .RegDst        (RegDst),
    .MemtoReg      (MemtoReg),
    .RegWrite      (regWriteDec)
  );

  // strobes drop immediately while reset is held so an aborted instruction writes nothing
  assign MemRead       = reset & memReadDec;
  assign MemWrite      = reset & memWriteDec;
  assign IRWrite       = reset & irWriteDec;
  assign PCWrite       = reset & pcWriteDec;
  assign PCWriteCondEQ = reset & condEqDec;
  assign PCWriteCondNE = reset & condNeDec;
  assign RegWrite      = reset & regWriteDec;
  assign Illegal       = illegalQ;
  assign State         = stateQ;

`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
  logic retireEvt;
  assign retireEvt = (stateNext == FETCH) &&
                     ((stateQ == MEM_WB) || (stateQ == MEM_WR) || (stateQ == ALU_WB) ||
                      (stateQ == BRANCH) || (stateQ == JUMP) || (stateQ == JAL_ST));

  always_ff @(posedge clk) begin
    if (!reset)         InstrRetired <= '0;
    else if (retireEvt) InstrRetired <= InstrRetired + 1'b1;
  end
`else
  logic [CNT_WIDTH-1:0] unusedCntWidth;
  assign unusedCntWidth = '0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - table-driven scoreboard bench for multicycle_control
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset, MemReady;
  logic [5:0] OP;
  logic       IorD, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCondEQ, PCWriteCondNE;
  logic [1:0] PCSource, ALUSrcB, RegDst, MemtoReg;
  logic       ALUSrcA, RegWrite, Illegal;
  logic [2:0] ALUOp;
  logic [3:0] State;
`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
  logic [31:0] InstrRetired;
`endif

  always #5 clk = ~clk;

  multicycle_control #(.MEM_WAIT_MAX(15), .CNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .OP(OP), .MemReady(MemReady),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .PCWriteCondEQ(PCWriteCondEQ), .PCWriteCondNE(PCWriteCondNE),
    .PCSource(PCSource), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .Illegal(Illegal),
`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
    .InstrRetired(InstrRetired),
`endif
    .State(State)
  );

  // {IorD,MemRead,MemWrite,IRWrite,PCWrite,EQ,NE,PCSource,ALUSrcA,ALUSrcB,ALUOp,RegDst,MemtoReg,RegWrite,Illegal}
  logic [20:0] ctlNow;
  assign ctlNow = {IorD, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCondEQ, PCWriteCondNE,
                   PCSource, ALUSrcA, ALUSrcB, ALUOp, RegDst, MemtoReg, RegWrite, Illegal};

  localparam logic [20:0] C_FETCH  = 21'b0_1_0_1_1_0_0_00_0_01_000_00_00_0_0;
  localparam logic [20:0] C_FETCH0 = 21'b0_1_0_0_0_0_0_00_0_01_000_00_00_0_0;
  localparam logic [20:0] C_DEC    = 21'b0_0_0_0_0_0_0_00_0_11_000_00_00_0_0;
  localparam logic [20:0] C_ADDI   = 21'b0_0_0_0_0_0_0_00_1_10_100_00_00_0_0;
  localparam logic [20:0] C_ORI    = 21'b0_0_0_0_0_0_0_00_1_10_101_00_00_0_0;
  localparam logic [20:0] C_WB_I   = 21'b0_0_0_0_0_0_0_00_0_00_000_00_00_1_0;
  localparam logic [20:0] C_WB_R   = 21'b0_0_0_0_0_0_0_00_0_00_000_01_00_1_0;
  localparam logic [20:0] C_EXR    = 21'b0_0_0_0_0_0_0_00_1_00_111_00_00_0_0;
  localparam logic [20:0] C_MADDR  = 21'b0_0_0_0_0_0_0_00_1_10_000_00_00_0_0;
  localparam logic [20:0] C_MRD    = 21'b1_1_0_0_0_0_0_00_0_00_000_00_00_0_0;
  localparam logic [20:0] C_MWB    = 21'b0_0_0_0_0_0_0_00_0_00_000_00_01_1_0;
  localparam logic [20:0] C_MWR    = 21'b1_0_1_0_0_0_0_00_0_00_000_00_00_0_0;
  localparam logic [20:0] C_BNE    = 21'b0_0_0_0_0_0_1_01_1_00_001_00_00_0_0;
  localparam logic [20:0] C_BEQ    = 21'b0_0_0_0_0_1_0_01_1_00_001_00_00_0_0;
  localparam logic [20:0] C_JUMP   = 21'b0_0_0_0_1_0_0_10_0_00_000_00_00_0_0;
  localparam logic [20:0] C_JAL    = 21'b0_0_0_0_1_0_0_10_0_00_000_10_10_1_0;
  localparam logic [20:0] C_ZERO   = 21'b0;
  localparam logic [20:0] M_ALL    = 21'h1fffff;
  localparam logic [20:0] M_NO_RD  = 21'b1_1_1_1_1_1_1_11_1_11_111_00_11_1_1;
  localparam logic [20:0] M_STROBE = 21'b0_1_1_1_1_1_1_00_0_00_000_00_00_1_0;

  typedef struct {
    logic        rstn;
    logic [5:0]  op;
    logic        rdy;
    logic [3:0]  st;
    logic [20:0] ctl;
    logic [20:0] mask;
  } vecT;

  typedef struct {
    int          idx;
    logic [3:0]  st;
    logic [20:0] ctl;
    logic [20:0] mask;
  } expT;

  vecT vecs[$];
  expT sbq[$];
  int  checks = 0;
  int  errors = 0;

  function automatic vecT mk(logic rstn, logic [5:0] op, logic rdy, logic [3:0] st,
                             logic [20:0] ctl, logic [20:0] mask);
    vecT v;
    v.rstn = rstn; v.op = op; v.rdy = rdy; v.st = st; v.ctl = ctl; v.mask = mask;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic applyVec(input vecT v, input int idx);
    expT e;
    @(negedge clk);
    reset = v.rstn; OP = v.op; MemReady = v.rdy;
    sbq.push_back('{idx, v.st, v.ctl, v.mask});
    #1;
    e = sbq.pop_front();
    checks++;
    if (State !== e.st) begin
      errors++;
      $display("FAIL vec%0d state: got %0d want %0d", e.idx, State, e.st);
    end
    checks++;
    if ((ctlNow & e.mask) !== (e.ctl & e.mask)) begin
      errors++;
      $display("FAIL vec%0d ctl: got %b want %b (mask %b)", e.idx, ctlNow, e.ctl, e.mask);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b0; MemReady = 1'b0;
    #1;
    chk("reset strobes comb", int'(ctlNow & M_STROBE), 0);
    @(posedge clk);
    #1;
    chk("reset state", int'(State), 0);
    chk("reset illegal", int'(Illegal), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; OP = 6'h00; MemReady = 1'b0;
    repeat (2) @(posedge clk);
    doReset();

    // ADDI, zero wait
    vecs.push_back(mk(1, 6'h08, 1, 0, C_FETCH, M_ALL));
    vecs.push_back(mk(1, 6'h08, 1, 1, C_DEC,   M_ALL));
    vecs.push_back(mk(1, 6'h08, 1, 7, C_ADDI,  M_ALL));
    vecs.push_back(mk(1, 6'h08, 1, 8, C_WB_I,  M_ALL));
    // LW, three wait cycles in MEM_RD
    vecs.push_back(mk(1, 6'h23, 1, 0, C_FETCH, M_ALL));
    vecs.push_back(mk(1, 6'h23, 1, 1, C_DEC,   M_ALL));
    vecs.push_back(mk(1, 6'h23, 1, 2, C_MADDR, M_ALL));
    vecs.push_back(mk(1, 6'h23, 0, 3, C_MRD,   M_ALL));
    vecs.push_back(mk(1, 6'h23, 0, 3, C_MRD,   M_ALL));
    vecs.push_back(mk(1, 6'h23, 0, 3, C_MRD,   M_ALL));
    vecs.push_back(mk(1, 6'h23, 1, 3, C_MRD,   M_ALL));
    vecs.push_back(mk(1, 6'h23, 1, 4, C_MWB,   M_ALL));
    // BNE
    vecs.push_back(mk(1, 6'h05, 1, 0, C_FETCH, M_ALL));
    vecs.push_back(mk(1, 6'h05, 1, 1, C_DEC,   M_ALL));
    vecs.push_back(mk(1, 6'h05, 1, 9, C_BNE,   M_ALL));
    // JAL
    vecs.push_back(mk(1, 6'h03, 1, 0,  C_FETCH, M_ALL));
    vecs.push_back(mk(1, 6'h03, 1, 1,  C_DEC,   M_ALL));
    vecs.push_back(mk(1, 6'h03, 1, 11, C_JAL,   M_ALL));
    // R-type
    vecs.push_back(mk(1, 6'h00, 1, 0, C_FETCH, M_ALL));
    vecs.push_back(mk(1, 6'h00, 1, 1, C_DEC,   M_ALL));
    vecs.push_back(mk(1, 6'h00, 1, 6, C_EXR,   M_NO_RD));
    vecs.push_back(mk(1, 6'h00, 1, 8, C_WB_R,  M_ALL));
    // SW, one wait cycle
    vecs.push_back(mk(1, 6'h2b, 1, 0, C_FETCH, M_ALL));
    vecs.push_back(mk(1, 6'h2b, 1, 1, C_DEC,   M_ALL));
    vecs.push_back(mk(1, 6'h2b, 1, 2, C_MADDR, M_ALL));
    vecs.push_back(mk(1, 6'h2b, 0, 5, C_MWR,   M_ALL));
    vecs.push_back(mk(1, 6'h2b, 1, 5, C_MWR,   M_ALL));
    // BEQ
    vecs.push_back(mk(1, 6'h04, 1, 0, C_FETCH, M_ALL));
    vecs.push_back(mk(1, 6'h04, 1, 1, C_DEC,   M_ALL));
    vecs.push_back(mk(1, 6'h04, 1, 9, C_BEQ,   M_ALL));
    // J
    vecs.push_back(mk(1, 6'h02, 1, 0,  C_FETCH, M_ALL));
    vecs.push_back(mk(1, 6'h02, 1, 1,  C_DEC,   M_ALL));
    vecs.push_back(mk(1, 6'h02, 1, 10, C_JUMP,  M_ALL));
    // ORI with one FETCH wait cycle
    vecs.push_back(mk(1, 6'h0d, 0, 0, C_FETCH0, M_ALL));
    vecs.push_back(mk(1, 6'h0d, 1, 0, C_FETCH,  M_ALL));
    vecs.push_back(mk(1, 6'h0d, 1, 1, C_DEC,    M_ALL));
    vecs.push_back(mk(1, 6'h0d, 1, 7, C_ORI,    M_ALL));
    vecs.push_back(mk(1, 6'h0d, 1, 8, C_WB_I,   M_ALL));
    // SW aborted by reset while waiting in MEM_WR, then rerun
    vecs.push_back(mk(1, 6'h2b, 1, 0, C_FETCH, M_ALL));
    vecs.push_back(mk(1, 6'h2b, 1, 1, C_DEC,   M_ALL));
    vecs.push_back(mk(1, 6'h2b, 1, 2, C_MADDR, M_ALL));
    vecs.push_back(mk(1, 6'h2b, 0, 5, C_MWR,   M_ALL));
    vecs.push_back(mk(0, 6'h2b, 0, 5, C_ZERO,  M_STROBE));
    vecs.push_back(mk(1, 6'h2b, 1, 0, C_FETCH, M_ALL));
    vecs.push_back(mk(1, 6'h2b, 1, 1, C_DEC,   M_ALL));
    vecs.push_back(mk(1, 6'h2b, 1, 2, C_MADDR, M_ALL));
    vecs.push_back(mk(1, 6'h2b, 1, 5, C_MWR,   M_ALL));
    vecs.push_back(mk(1, 6'h2b, 1, 0, C_FETCH, M_ALL));

    for (int i = 0; i < vecs.size(); i++) applyVec(vecs[i], i);

    // illegal opcode traps and sticks until reset
    doReset();
    @(negedge clk);
    reset = 1'b1; OP = 6'h3f; MemReady = 1'b1;
    @(negedge clk); #1;
    chk("illegal decode state", int'(State), 1);
    @(negedge clk); #1;
    chk("illegal trap state", int'(State), 12);
    chk("illegal flag", int'(Illegal), 1);
    chk("trap strobes", int'(ctlNow & M_STROBE), 0);
    repeat (3) @(negedge clk);
    #1;
    chk("trap held state", int'(State), 12);
    chk("trap held flag", int'(Illegal), 1);
    doReset();

    // FETCH timeout: fifteen wait cycles then TRAP in cycle 16
    @(negedge clk);
    reset = 1'b1; OP = 6'h08; MemReady = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      if (k > 1) @(negedge clk);
      #1;
      chk($sformatf("timeout cycle %0d", k), int'(State), (k == 16) ? 12 : 0);
    end
    chk("timeout illegal", int'(Illegal), 1);
    doReset();

    // ready arriving on the timeout cycle completes the fetch
    @(negedge clk);
    reset = 1'b1; MemReady = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 15) MemReady = 1'b1;
      #1;
      chk($sformatf("late ready cycle %0d", k), int'(State), 0);
    end
    @(negedge clk); #1;
    chk("late ready decode", int'(State), 1);
    chk("late ready no trap", int'(Illegal), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style FSM sequencing a multicycle MIPS datapath: one shared memory, one ALU, instruction/data registers.
- Replaces single-cycle opcode decode with per-state control strobes.
- Supports R-type, ADDI, ORI, ANDI, LUI, LW, SW, BEQ, BNE, J, JAL.
- Inserts memory wait states via a ready handshake; traps illegal opcodes.

Parameters:
- MEM_WAIT_MAX, 15: max consecutive cycles waiting on MemReady before a timeout trap; 0 disables the timeout.
- CNT_WIDTH, 32: width of the retired-instruction counter (optional feature only).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset
- OP  in  6  opcode field of the instruction register
- MemReady  in  1  memory completes the current access this cycle
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  load instruction register
- PCWrite  out  1  unconditional PC load
- PCWriteCondEQ  out  1  load PC if ALU Zero
- PCWriteCondNE  out  1  load PC if ALU not Zero
- PCSource  out  2  next-PC select: 00 ALU, 01 ALUOut, 10 jump target
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = rs
- ALUSrcB  out  2  ALU B select: 00 rt, 01 const 4, 10 sign-ext imm, 11 imm<<2
- ALUOp  out  3  ALU operation code
- RegDst  out  2  write-register select: 00 rt, 01 rd, 10 $31
- MemtoReg  out  2  write-data select: 00 ALUOut, 01 MDR, 10 PC
- RegWrite  out  1  register file write strobe
- Illegal  out  1  sticky trap flag
- State  out  4  current state, for debug

Behaviour:
- Reset: when reset=0 at a clk edge, State goes to FETCH (0), Illegal=0, wait counter=0. While reset=0, all strobes are forced 0 combinationally: MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond*, RegWrite. Reset mid-instruction aborts it with no partial writes afterwards.
- Outputs are decoded from State only. Exceptions: PCWrite/IRWrite in FETCH and the MDR capture in MEM_RD are qualified by MemReady. Unlisted selects are 0.
- FETCH (0): MemRead, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=ADD, PCSource=00. IRWrite and PCWrite equal MemReady. Go to DECODE on MemReady, else stay.
- DECODE (1): ALUSrcA=0, ALUSrcB=11, ALUOp=ADD (branch target into ALUOut). Dispatch on OP:
  - LW/SW -> MEM_ADDR
  - R -> EXEC_R
  - ADDI/ORI/ANDI/LUI -> EXEC_I
  - BEQ/BNE -> BRANCH
  - J -> JUMP
  - JAL -> JAL_ST
  - other -> TRAP
- MEM_ADDR (2): ALUSrcA=1, ALUSrcB=10, ALUOp=ADD. Go to MEM_RD for LW, MEM_WR for SW.
- MEM_RD (3): MemRead, IorD=1. Stay until MemReady, then go to MEM_WB.
- MEM_WB (4): RegDst=00, MemtoReg=01, RegWrite. Go to FETCH.
- MEM_WR (5): MemWrite, IorD=1. Stay until MemReady, then go to FETCH.
- EXEC_R (6): ALUSrcA=1, ALUSrcB=00, ALUOp=FUNCT. Go to ALU_WB with RegDst=01.
- EXEC_I (7): ALUSrcA=1, ALUSrcB=10, ALUOp=ADDI/ORI/ANDI/LUI code. Go to ALU_WB with RegDst=00.
- ALU_WB (8): MemtoReg=00, RegWrite. RegDst is held from the previous state by a registered rtype flag. Go to FETCH.
- BRANCH (9): ALUSrcA=1, ALUSrcB=00, ALUOp=SUB, PCSource=01. PCWriteCondEQ for BEQ, PCWriteCondNE for BNE. Go to FETCH.
- JUMP (10): PCWrite, PCSource=10. Go to FETCH.
- JAL_ST (11): PCWrite, PCSource=10, RegDst=10, MemtoReg=10, RegWrite. The PC already holds PC+4. Go to FETCH.
- TRAP (12): all strobes 0, Illegal=1. Stays here until reset.
- Unused encodings 13-15 go to FETCH next cycle with strobes 0.
- Latency with zero-wait memory, in cycles: R/I-ALU 4, LW 5, SW 4, BEQ/BNE 3, J/JAL 3. Each wait cycle adds 1.
- Timeout: the wait counter increments each cycle in FETCH/MEM_RD/MEM_WR with MemReady=0 and clears on leaving the state. When it reaches MEM_WAIT_MAX with MemReady still 0, go to TRAP.
- MemReady is ignored in all other states. Asserting MemReady together with the timeout hit completes the access, with no trap.

Optional Feature:
- Macro: MULTICYCLE_CTRL_RETIRE_CNT_EN.
- Enabled:
  - Adds output InstrRetired[CNT_WIDTH-1:0].
  - Increments on every transition into FETCH from MEM_WB, MEM_WR, ALU_WB, BRANCH, JUMP or JAL_ST.
  - Wraps modulo 2^CNT_WIDTH; cleared by reset.
- Disabled: port and logic are absent.

Decomposition:
- Shared package/include mips_ctrl_pkg holds:
  - opcodes (R 0x00, ADDI 0x08, ORI 0x0d, ANDI 0x0c, LUI 0x0f, LW 0x23, SW 0x2b, BEQ 0x04, BNE 0x05, J 0x02, JAL 0x03)
  - state encodings 0-12
  - ALUOp codes: ADD 000, SUB 001, LUI 011, ADDI 100, ORI 101, ANDI 110, FUNCT 111
  - mux select codes
- One sub-module, multicycle_ctrl_decode: combinational State/OP -> control outputs. The top holds the state register, wait counter and counter.

Test Plan:
- ADDI (OP=0x08), MemReady tied 1: State sequence 0,1,7,8,0. RegWrite high only in cycle 4 with ALUOp=100 in cycle 3. PCWrite/IRWrite high in cycle 1 only.
- LW with MemReady low for 3 cycles in MEM_RD: State holds 3 for 4 cycles. MemRead/IorD=1 throughout. MEM_WB RegWrite follows with MemtoReg=01.
- BNE: State 0,1,9,0. PCWriteCondNE=1, PCWriteCondEQ=0, PCSource=01, ALUOp=001 in state 9.
- JAL: State 0,1,11. RegDst=10, MemtoReg=10, RegWrite=1, PCWrite=1, PCSource=10 in the same cycle.
- OP=0x3f: State goes 1 to 12, Illegal=1 and stays. reset=0 for one edge clears Illegal and gives State=0.
- reset dropped in MEM_WR with MemReady=0: MemWrite deasserts immediately. Next edge State=0. MEM_WAIT_MAX=15 with no MemReady in FETCH gives TRAP on cycle 16.
